ps2_receiver: RTL and testbench
===============================

Name: ps2_receiver

Overview:
- Upstream feeder of the memory-map PS/2 read register.
- Deserialises PS/2 keyboard frames and decodes the E0 (extended) and F0 (break) prefixes.
- Presents a 32-bit status/scancode word on dataForPS2, which the memory map returns at address 6'b111_110.
- Runs in the system clk domain; ps2_clk and ps2_data are asynchronous pad inputs.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples needed before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the pad.
- ps2_data  input  1  raw PS/2 data from the pad.
- dataForPS2  output  32  status word consumed by the memory map.
- new_code  output  1  one-cycle pulse when dataForPS2[9:0] is updated.

Behaviour:
- Reset (reset=0, asynchronous): dataForPS2=32'h0, new_code=0, FSM=IDLE, prefix flags cleared, filter output=1, both synchronisers=1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered ps2_clk changes level only after FILTER_LEN identical consecutive synchronised samples.
  - fall = filtered level 1->0, registered as a one-cycle strobe.
  - ps2_data is sampled (synchronised value) in the cycle fall is asserted.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA and clear bit count. A fall with data=1 is ignored.
  - DATA: on each fall, shift data into bit 7 of the shift register (LSB arrives first). After the 8th bit go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame and always return to IDLE.
- Frame valid when XOR(8 data bits, parity bit)=1 (odd parity) and stop bit=1.
- Valid byte handling, applied in the cycle after the stop-bit fall:
  - 8'hE0: set ext_pend; dataForPS2[9:0] unchanged; no new_code.
  - 8'hF0: set brk_pend; dataForPS2[9:0] unchanged; no new_code.
  - Any other byte: commit [7:0]=byte, [8]=brk_pend, [9]=ext_pend; clear both flags; pulse new_code for exactly 1 cycle.
  - frame_cnt increments for every valid frame, including prefixes.
- Invalid frame: byte and pending flags discarded (flags kept as they were); err_cnt increments; no new_code.
- Timeout: in DATA, PARITY or STOP, a watchdog counts clk cycles and resets on every fall. When it reaches TIMEOUT_CYCLES the FSM returns to IDLE, partial data is dropped, err_cnt increments and pending flags are kept. The watchdog is idle in IDLE.
- dataForPS2 layout:
  - [7:0] last scancode
  - [8] break
  - [9] extended
  - [15:10] 0
  - [23:16] frame_cnt, wraps 255->0
  - [31:24] err_cnt, saturates at 255
- Latency: dataForPS2 and new_code update 1 clk after the stop-bit fall strobe, which itself lags the pad edge by 2 (sync) + FILTER_LEN + 1 cycles.
- A reset mid-frame aborts the frame immediately; no partial commit.
- All outputs are registered; no combinational path from the pads.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - localparams PS2_EXT=8'hE0 and PS2_BRK=8'hF0
  - bit-field index constants for the dataForPS2 layout, shared with the memory map.
- One sub-module: ps2_in_filter. It holds the 2-FF synchronisers, the glitch filter and the fall strobe generator, with outputs fall and data_s.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> dataForPS2=32'h0 and new_code=0. Release, then send frame 8'h1C with correct parity and stop -> dataForPS2=32'h0001_001C and one new_code pulse.
- Break and extended: send E0, F0, 74 -> dataForPS2[9:0]=10'h374, frame_cnt=3, exactly one new_code pulse, and it follows the 74 frame.
- Parity error: send 8'h1C with even parity -> [7:0] unchanged, err_cnt=1, no new_code. A following valid 8'h32 commits with [8]=0.
- Glitch and timeout:
  - A 3-cycle low glitch on ps2_clk in IDLE -> no state change.
  - Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+10 cycles -> FSM=IDLE, err_cnt increments.
  - The next valid frame 8'h29 then decodes correctly.
- Counter boundaries:
  - 256 valid frames of 8'h15 -> frame_cnt wraps to 8'h00.
  - 300 parity errors -> err_cnt stays at 8'hFF.
- Reset mid-frame: assert reset after 5 data bits -> outputs 0 immediately. A subsequent full frame 8'h5A decodes to [7:0]=8'h5A.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and the dataForPS2 field map.
// The memory-map PS/2 read register uses the same field map.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int CODE_LSB  = 0;
  localparam int CODE_MSB  = 7;
  localparam int BRK_BIT   = 8;
  localparam int EXT_BIT   = 9;
  localparam int RSVD_LSB  = 10;
  localparam int RSVD_MSB  = 15;
  localparam int FRAME_LSB = 16;
  localparam int FRAME_MSB = 23;
  localparam int ERR_LSB   = 24;
  localparam int ERR_MSB   = 31;

  // Odd parity: the data bits and the parity bit together hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_if.sv
// Status bus from the PS/2 receiver to the memory map.
interface ps2_if;
  logic [31:0] dataForPS2;
  logic        new_code;

  modport master (output dataForPS2, output new_code);
  modport slave  (input  dataForPS2, input  new_code);
endinterface

// File: rtl/ps2_in_filter.sv
// Pad conditioning: 2-FF synchronisers, ps2_clk glitch filter and the falling-edge strobe.
module ps2_in_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clkSync;
  logic [1:0]    dataSync;
  logic          clkLevel;
  logic          clkLevelDly;
  logic [CW-1:0] runCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkSync     <= 2'b11;
      dataSync    <= 2'b11;
      clkLevel    <= 1'b1;
      clkLevelDly <= 1'b1;
      runCnt      <= '0;
      fall        <= 1'b0;
    end else begin
      clkSync     <= {clkSync[0], ps2_clk};
      dataSync    <= {dataSync[0], ps2_data};
      clkLevelDly <= clkLevel;
      fall        <= clkLevelDly & ~clkLevel;
      // Any sample matching the current level restarts the run, so only an unbroken
      // run of FILTER_LEN opposite samples moves the filtered level.
      if (clkSync[1] == clkLevel) begin
        runCnt <= '0;
      end else if (runCnt == RUN_LAST) begin
        clkLevel <= clkSync[1];
        runCnt   <= '0;
      end else begin
        runCnt <= runCnt + 1'b1;
      end
    end
  end

  assign data_s = dataSync[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver with E0/F0 prefix decoding, feeding the memory-map read word.
//
// state  | meaning
// IDLE   | waiting for a start bit (fall with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then evaluate and commit
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_if.master bus
);

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic fall;
  logic dataS;

  ps2State_t   state;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic        parityBit;
  logic        extPend;
  logic        brkPend;
  logic [7:0]  scanCode;
  logic        brkBit;
  logic        extBit;
  logic [7:0]  frameCnt;
  logic [7:0]  errCnt;
  logic        newCode;
  logic [WD_W-1:0] wdog;

  ps2_in_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (dataS)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      extPend   <= 1'b0;
      brkPend   <= 1'b0;
      scanCode  <= '0;
      brkBit    <= 1'b0;
      extBit    <= 1'b0;
      frameCnt  <= '0;
      errCnt    <= '0;
      newCode   <= 1'b0;
      wdog      <= WD_LOAD;
    end else begin
      newCode <= 1'b0;
      if (state == IDLE) begin
        if (fall && !dataS) begin
          state  <= DATA;
          bitCnt <= '0;
          wdog   <= WD_LOAD;
        end
      end else if (!fall) begin
        // Mid-frame watchdog: a stalled keyboard clock abandons the partial frame.
        if (wdog == '0) begin
          state  <= IDLE;
          errCnt <= satInc8(errCnt);
        end else begin
          wdog <= wdog - 1'b1;
        end
      end else begin
        wdog <= WD_LOAD;
        unique case (state)
          DATA: begin
            shiftReg <= {dataS, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parityBit <= dataS;
            state     <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (oddParityOk(shiftReg, parityBit) && dataS) begin
              frameCnt <= frameCnt + 8'd1;
              if (shiftReg == PS2_EXT) begin
                extPend <= 1'b1;
              end else if (shiftReg == PS2_BRK) begin
                brkPend <= 1'b1;
              end else begin
                scanCode <= shiftReg;
                brkBit   <= brkPend;
                extBit   <= extPend;
                brkPend  <= 1'b0;
                extPend  <= 1'b0;
                newCode  <= 1'b1;
              end
            end else begin
              errCnt <= satInc8(errCnt);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.dataForPS2                      = '0;
    bus.dataForPS2[CODE_MSB:CODE_LSB]   = scanCode;
    bus.dataForPS2[BRK_BIT]             = brkBit;
    bus.dataForPS2[EXT_BIT]             = extBit;
    bus.dataForPS2[FRAME_MSB:FRAME_LSB] = frameCnt;
    bus.dataForPS2[ERR_MSB:ERR_LSB]     = errCnt;
  end

  assign bus.new_code = newCode;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frames driven on the pads, status word checked after each scenario.
module tb_ps2_receiver;

  localparam int FILT = 4;
  localparam int TMO  = 200;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic ps2Clk  = 1'b1;
  logic ps2Data = 1'b1;

  int errors   = 0;
  int checks   = 0;
  int pulseCnt = 0;
  int wideCnt  = 0;
  logic prevNew = 1'b0;

  ps2_if bus ();

  ps2_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.new_code) pulseCnt++;
    if (bus.new_code && prevNew) wideCnt++;
    prevNew = bus.new_code;
  end

  task automatic doReset();
    reset   = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock is high, 5-cycle low phase, 5-cycle high phase.
  task automatic sendBit(input logic b);
    ps2Data = b;
    repeat (2) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badParity);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~(^b) ^ badParity);
    sendBit(1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int p0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dataForPS2 !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected %h", bus.dataForPS2, 32'h0);
    end
    checks++;
    if (bus.new_code !== 1'b0) begin
      errors++; $display("FAIL reset_new_code: got %b expected 0", bus.new_code);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    p0 = pulseCnt;
    sendFrame(8'h1C, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0001_001C) begin
      errors++; $display("FAIL first_frame: got %h expected %h", bus.dataForPS2, 32'h0001_001C);
    end
    checks++;
    if (pulseCnt - p0 !== 1) begin
      errors++; $display("FAIL first_frame_pulses: got %0d expected 1", pulseCnt - p0);
    end
  endtask

  task automatic test_break_ext();
    int p0;
    doReset();
    p0 = pulseCnt;
    sendFrame(8'hE0, 1'b0);
    checks++;
    if (pulseCnt - p0 !== 0) begin
      errors++; $display("FAIL e0_no_pulse: got %0d expected 0", pulseCnt - p0);
    end
    sendFrame(8'hF0, 1'b0);
    checks++;
    if (pulseCnt - p0 !== 0 || bus.dataForPS2[9:0] !== 10'h000) begin
      errors++; $display("FAIL f0_no_commit: got pulses %0d low %h expected 0 / 000", pulseCnt - p0, bus.dataForPS2[9:0]);
    end
    sendFrame(8'h74, 1'b0);
    checks++;
    if (bus.dataForPS2[9:0] !== 10'h374) begin
      errors++; $display("FAIL ext_brk_code: got %h expected %h", bus.dataForPS2[9:0], 10'h374);
    end
    checks++;
    if (bus.dataForPS2[23:16] !== 8'd3) begin
      errors++; $display("FAIL ext_brk_frames: got %0d expected 3", bus.dataForPS2[23:16]);
    end
    checks++;
    if (pulseCnt - p0 !== 1) begin
      errors++; $display("FAIL ext_brk_pulses: got %0d expected 1", pulseCnt - p0);
    end
    sendFrame(8'h1C, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0004_001C) begin
      errors++; $display("FAIL flags_cleared: got %h expected %h", bus.dataForPS2, 32'h0004_001C);
    end
  endtask

  task automatic test_parity_error();
    int p0;
    doReset();
    p0 = pulseCnt;
    sendFrame(8'h1C, 1'b1);
    checks++;
    if (bus.dataForPS2 !== 32'h0100_0000) begin
      errors++; $display("FAIL parity_err_word: got %h expected %h", bus.dataForPS2, 32'h0100_0000);
    end
    checks++;
    if (pulseCnt - p0 !== 0) begin
      errors++; $display("FAIL parity_err_pulse: got %0d expected 0", pulseCnt - p0);
    end
    sendFrame(8'h32, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0101_0032) begin
      errors++; $display("FAIL after_parity_err: got %h expected %h", bus.dataForPS2, 32'h0101_0032);
    end
  endtask

  task automatic test_glitch_timeout();
    int p0;
    doReset();
    ps2Data = 1'b0;
    @(negedge clk);
    ps2Clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b1;
    @(negedge clk);
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);
    sendFrame(8'h29, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0001_0029) begin
      errors++; $display("FAIL glitch_ignored: got %h expected %h", bus.dataForPS2, 32'h0001_0029);
    end
    p0 = pulseCnt;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    checks++;
    if (bus.dataForPS2 !== 32'h0101_0029) begin
      errors++; $display("FAIL timeout_err: got %h expected %h", bus.dataForPS2, 32'h0101_0029);
    end
    checks++;
    if (pulseCnt - p0 !== 0) begin
      errors++; $display("FAIL timeout_pulse: got %0d expected 0", pulseCnt - p0);
    end
    sendFrame(8'h29, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0102_0029 || pulseCnt - p0 !== 1) begin
      errors++; $display("FAIL after_timeout: got %h pulses %0d expected %h pulses 1", bus.dataForPS2, pulseCnt - p0, 32'h0102_0029);
    end
  endtask

  task automatic test_counters();
    int p0;
    doReset();
    p0 = pulseCnt;
    for (int i = 0; i < 256; i++) sendFrame(8'h15, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0000_0015) begin
      errors++; $display("FAIL frame_wrap: got %h expected %h", bus.dataForPS2, 32'h0000_0015);
    end
    checks++;
    if (pulseCnt - p0 !== 256) begin
      errors++; $display("FAIL frame_wrap_pulses: got %0d expected 256", pulseCnt - p0);
    end
    for (int i = 0; i < 300; i++) sendFrame(8'h15, 1'b1);
    checks++;
    if (bus.dataForPS2 !== 32'hFF00_0015) begin
      errors++; $display("FAIL err_saturate: got %h expected %h", bus.dataForPS2, 32'hFF00_0015);
    end
  endtask

  task automatic test_reset_midframe();
    doReset();
    sendFrame(8'h1C, 1'b0);
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dataForPS2 !== 32'h0 || bus.new_code !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: got %h / %b expected 0 / 0", bus.dataForPS2, bus.new_code);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    sendFrame(8'h5A, 1'b0);
    checks++;
    if (bus.dataForPS2 !== 32'h0001_005A) begin
      errors++; $display("FAIL after_midframe_reset: got %h expected %h", bus.dataForPS2, 32'h0001_005A);
    end
  endtask

  initial begin
    test_reset();
    test_break_ext();
    test_parity_error();
    test_glitch_timeout();
    test_counters();
    test_reset_midframe();
    checks++;
    if (wideCnt !== 0) begin
      errors++; $display("FAIL new_code_width: got %0d wide pulses expected 0", wideCnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
